// File: rtl/ptr_reader_pkg.sv
// Shared pdp6 IO-bus definitions for the paper-tape reader: bus width,
// CONO/CONI bit positions, controller states and the PI level encoder.
package ptr_reader_pkg;

  localparam int IOB_W = 36;

  localparam int PTR_PIA_HI = 2;
  localparam int PTR_PIA_LO = 0;
  localparam int PTR_DONE   = 3;
  localparam int PTR_BUSY   = 4;
  localparam int PTR_BINARY = 5;
  localparam int PTR_TAPE   = 6;

  localparam int WORD_FRAMES = 6;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    DONE       = 2'd2
  } ptr_state_e;

  // Level 1 is the MSB of the request bus; level 0 means "no PI assigned".
  function automatic logic [6:0] pi_onehot(input logic [2:0] pia);
    logic [6:0] req;
    req = 7'd0;
    if (pia != 3'd0) begin
      req = 7'b1000000 >> (pia - 3'd1);
    end else begin
      req = 7'd0;
    end
    return req;
  endfunction

endpackage

// File: rtl/ptr_frame_gate.sv
// Tape frame handshake: accepts a frame only when armed and the mechanical
// gap since the previous accepted frame has elapsed.
module ptr_frame_gate #(
  parameter int FRAME_GAP = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic armed,
  input  logic tape_valid,
  output logic tape_ready,
  output logic frame_take
);

  localparam int GAP_W = (FRAME_GAP > 2) ? $clog2(FRAME_GAP) : 1;

  logic [GAP_W-1:0] gap_r;
  logic             take_s;

  // Frame acceptance decision
  always_comb begin
    take_s = armed && tape_valid && (gap_r == GAP_W'(0));
  end

  // Gap counter keeps running across CONO so the reader rate is never exceeded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_r <= GAP_W'(0);
    end else if (take_s) begin
      gap_r <= GAP_W'(FRAME_GAP - 1);
    end else if (gap_r != GAP_W'(0)) begin
      gap_r <= gap_r - GAP_W'(1);
    end else begin
      gap_r <= gap_r;
    end
  end

  assign tape_ready = take_s;
  assign frame_take = take_s;

endmodule

// File: rtl/ptr_reader.sv
// Paper-tape reader controller (device 104): assembles tape frames into
// words for DATAI, answers CONI/CONO and requests a PI level when done.
module ptr_reader
  import ptr_reader_pkg::*;
#(
  parameter logic [6:0] DEV_CODE  = 7'o21,
  parameter int         FRAME_GAP = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       iobus_ios,
  input  logic             iobus_cono_set,
  input  logic             iobus_datai,
  input  logic             iobus_datai_done,
  input  logic             iobus_status,
  input  logic [IOB_W-1:0] iobus_iob_in,
  output logic [IOB_W-1:0] iobus_iob_out,
  output logic [6:0]       iobus_pi_req,
  input  logic             tape_valid,
  input  logic [7:0]       tape_frame,
  output logic             tape_ready,
  input  logic             tape_present
);

  ptr_state_e       state_r, state_nxt_s;
  logic [2:0]       pia_r, pia_nxt_s;
  logic             binary_r, binary_nxt_s;
  logic [IOB_W-1:0] buf_r, buf_nxt_s;
  logic [2:0]       cnt_r, cnt_nxt_s;
  logic [6:0]       pi_req_r;

  logic             sel_s, cono_hit_s, ddone_hit_s;
  logic             busy_s, done_s, armed_s, frame_take_s;
  logic [IOB_W-1:0] coni_s;
  logic             unused_iob_s;

  assign unused_iob_s = ^{iobus_iob_in[IOB_W-1:PTR_TAPE], iobus_iob_in[PTR_DONE]};

  // Bus decode and status flags derived from the controller state
  always_comb begin
    sel_s       = (iobus_ios == DEV_CODE);
    cono_hit_s  = sel_s && iobus_cono_set;
    ddone_hit_s = sel_s && iobus_datai_done;
    busy_s      = (state_r == WAIT_FRAME);
    done_s      = (state_r == DONE);
    // CONO and DATAI completion both pre-empt a frame arriving the same cycle
    armed_s     = busy_s && !cono_hit_s && !ddone_hit_s;
  end

  ptr_frame_gate #(
    .FRAME_GAP (FRAME_GAP)
  ) u_gate (
    .clk        (clk),
    .reset_n    (reset_n),
    .armed      (armed_s),
    .tape_valid (tape_valid),
    .tape_ready (tape_ready),
    .frame_take (frame_take_s)
  );

  // Next-state and datapath update; CONO beats DATAI completion beats tape
  always_comb begin
    state_nxt_s  = state_r;
    pia_nxt_s    = pia_r;
    binary_nxt_s = binary_r;
    buf_nxt_s    = buf_r;
    cnt_nxt_s    = cnt_r;
    if (cono_hit_s) begin
      pia_nxt_s    = iobus_iob_in[PTR_PIA_HI:PTR_PIA_LO];
      binary_nxt_s = iobus_iob_in[PTR_BINARY];
      buf_nxt_s    = 36'd0;
      cnt_nxt_s    = 3'd0;
      if (iobus_iob_in[PTR_BUSY]) begin
        state_nxt_s = WAIT_FRAME;
      end else begin
        state_nxt_s = IDLE;
      end
    end else if (ddone_hit_s) begin
      buf_nxt_s   = 36'd0;
      cnt_nxt_s   = 3'd0;
      state_nxt_s = WAIT_FRAME;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        WAIT_FRAME: begin
          if (!frame_take_s) begin
            state_nxt_s = WAIT_FRAME;
          end else if (!binary_r) begin
            buf_nxt_s   = {28'd0, tape_frame};
            state_nxt_s = DONE;
          end else if (tape_frame[7]) begin
            buf_nxt_s = {buf_r[IOB_W-7:0], tape_frame[5:0]};
            if (cnt_r == 3'(WORD_FRAMES - 1)) begin
              cnt_nxt_s   = 3'd0;
              state_nxt_s = DONE;
            end else begin
              cnt_nxt_s = cnt_r + 3'd1;
            end
          end else begin
            // Frames without hole 8 are leader/blank tape: consumed, not shifted
            state_nxt_s = WAIT_FRAME;
          end
        end
        DONE: begin
          state_nxt_s = DONE;
        end
        default: begin
          state_nxt_s = IDLE;
          buf_nxt_s   = 36'd0;
          cnt_nxt_s   = 3'd0;
        end
      endcase
    end
  end

  // Controller state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      pia_r    <= 3'd0;
      binary_r <= 1'b0;
      buf_r    <= 36'd0;
      cnt_r    <= 3'd0;
    end else begin
      state_r  <= state_nxt_s;
      pia_r    <= pia_nxt_s;
      binary_r <= binary_nxt_s;
      buf_r    <= buf_nxt_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  // PI request follows done/pia with one cycle of latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pi_req_r <= 7'd0;
    end else if (done_s) begin
      pi_req_r <= pi_onehot(pia_r);
    end else begin
      pi_req_r <= 7'd0;
    end
  end

  // CONI status word
  always_comb begin
    coni_s                        = 36'd0;
    coni_s[PTR_PIA_HI:PTR_PIA_LO] = pia_r;
    coni_s[PTR_DONE]              = done_s;
    coni_s[PTR_BUSY]              = busy_s;
    coni_s[PTR_BINARY]            = binary_r;
    coni_s[PTR_TAPE]              = tape_present;
  end

  // Read mux onto the IO bus; zero whenever this device is not selected
  always_comb begin
    if (sel_s && iobus_datai) begin
      iobus_iob_out = buf_r;
    end else if (sel_s && iobus_status) begin
      iobus_iob_out = coni_s;
    end else begin
      iobus_iob_out = 36'd0;
    end
  end

  assign iobus_pi_req = pi_req_r;

endmodule

// File: tb/tb_ptr_reader.sv
// Self-checking bench for ptr_reader: directed test-plan scenarios followed
// by random bus/tape traffic against a cycle-level behavioural model.
module tb_ptr_reader;

  localparam logic [6:0] DEV = 7'o21;
  localparam int         GAP = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  ios;
  logic        cono_set, datai, datai_done, status;
  logic [35:0] iob_in, iob_out;
  logic [6:0]  pi_req;
  logic        tape_valid, tape_ready, tape_present;
  logic [7:0]  tape_frame;

  always #5 clk = ~clk;

  ptr_reader #(.DEV_CODE(7'o21), .FRAME_GAP(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .iobus_ios        (ios),
    .iobus_cono_set   (cono_set),
    .iobus_datai      (datai),
    .iobus_datai_done (datai_done),
    .iobus_status     (status),
    .iobus_iob_in     (iob_in),
    .iobus_iob_out    (iob_out),
    .iobus_pi_req     (pi_req),
    .tape_valid       (tape_valid),
    .tape_frame       (tape_frame),
    .tape_ready       (tape_ready),
    .tape_present     (tape_present)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // behavioural model of the controller as seen from the bus
  bit          m_busy, m_done, m_bin, m_acc, obs_ready;
  bit [2:0]    m_pia;
  logic [35:0] m_buf;
  int          m_nfr, m_last;
  logic [6:0]  m_pi;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0; m_done = 0; m_bin = 0; m_pia = 3'd0; m_buf = 36'd0;
    m_nfr = 0; m_last = -1000; m_pi = 7'd0; m_acc = 0;
  endfunction

  task automatic idle_inputs();
    ios = DEV; cono_set = 0; datai = 0; datai_done = 0; status = 0;
    tape_valid = 0;
  endtask

  // one clock: compare outputs mid-cycle, then advance the model at the edge
  task automatic step();
    bit          sel, cono_hit, dd_hit;
    logic [35:0] exp_out;
    if (!reset_n) model_reset();
    #1;
    sel      = (ios == DEV);
    cono_hit = sel && cono_set;
    dd_hit   = sel && datai_done;
    m_acc    = reset_n && m_busy && tape_valid && !cono_hit && !dd_hit && (cyc - m_last >= GAP);
    exp_out  = 36'd0;
    if (sel && datai) exp_out = m_buf;
    else if (sel && status)
      exp_out = (36'(tape_present) << 6) | (36'(m_bin) << 5) | (36'(m_busy) << 4)
              | (36'(m_done) << 3) | 36'(m_pia);
    check("tape_ready", 36'(tape_ready), 36'(m_acc));
    check("iob_out", iob_out, exp_out);
    check("pi_req", 36'(pi_req), 36'(m_pi));
    obs_ready = tape_ready;
    @(posedge clk);
    if (reset_n) begin
      m_pi = (m_done && m_pia != 3'd0) ? 7'(1 << (7 - int'(m_pia))) : 7'd0;
      if (cono_hit) begin
        m_pia = iob_in[2:0]; m_bin = iob_in[5]; m_busy = iob_in[4];
        m_done = 0; m_buf = 36'd0; m_nfr = 0;
      end else if (dd_hit) begin
        m_done = 0; m_busy = 1; m_buf = 36'd0; m_nfr = 0;
      end else if (m_acc) begin
        m_last = cyc;
        if (!m_bin) begin
          m_buf = 36'(tape_frame); m_busy = 0; m_done = 1;
        end else if (tape_frame >= 8'd128) begin
          m_buf = 36'((m_buf * 64) + (tape_frame % 64));
          m_nfr++;
          if (m_nfr == 6) begin
            m_nfr = 0; m_busy = 0; m_done = 1;
          end
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic cono(input logic [35:0] v);
    cono_set = 1; iob_in = v;
    step();
    cono_set = 0;
  endtask

  task automatic feed(input logic [7:0] f);
    tape_valid = 1; tape_frame = f;
    for (int k = 0; k < 40; k++) begin
      step();
      if (m_acc) break;
    end
    check("feed_taken", 36'(m_acc), 36'd1);
    tape_valid = 0;
  endtask

  task automatic read_datai(input string tag, input logic [35:0] exp);
    datai = 1; #1;
    check(tag, iob_out, exp);
    step();
    datai = 0;
  endtask

  initial begin
    int prev, npulse;
    model_reset();
    idle_inputs();
    iob_in = 36'd0; tape_frame = 8'd0; tape_present = 1; reset_n = 0;
    @(negedge clk);
    step(); step();
    reset_n = 1;
    status = 1; #1;
    check("reset_coni", iob_out, 36'o000100);
    step(); status = 0;

    // 1: binary word, pia 4
    cono(36'o000064);
    for (int i = 1; i <= 6; i++) feed(8'h80 | 8'(i));
    step();
    check("t1_pi", 36'(pi_req), 36'(7'b0001000));
    read_datai("t1_word", 36'o010203040506);

    // 2: blank frames interleaved are consumed but not shifted
    cono(36'o000064);
    for (int i = 1; i <= 6; i++) begin
      feed(8'h80 | 8'(i));
      if (i < 6) begin
        feed(8'h01);
        check("t2_blank_rdy", 36'(obs_ready), 36'd1);
      end
    end
    step();
    read_datai("t2_word", 36'o010203040506);

    // 3: ASCII frame, pia 1, then DATAI completion re-arms
    cono(36'o000021);
    feed(8'h41);
    step();
    check("t3_pi", 36'(pi_req), 36'(7'b1000000));
    read_datai("t3_word", 36'o101);
    datai_done = 1; step(); datai_done = 0;
    status = 1; #1;
    check("t3_coni", iob_out, 36'o000121);
    step(); status = 0;

    // 4: back-to-back frames are taken exactly GAP cycles apart
    cono(36'o000064);
    tape_valid = 1; tape_frame = 8'h80 | 8'($urandom_range(0, 127));
    prev = -1; npulse = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (obs_ready) begin
        if (prev >= 0) check("t4_gap", 36'(cyc - prev), 36'd8);
        prev = cyc; npulse++;
      end
    end
    tape_valid = 0;
    check("t4_pulses", 36'(npulse), 36'd6);

    // 5: CONO busy=0 part way through a word aborts it
    cono(36'o000064);
    for (int i = 0; i < 3; i++) feed(8'h87);
    cono(36'o000040);
    status = 1; #1;
    check("t5_coni", iob_out, 36'o000140);
    step(); status = 0;
    read_datai("t5_buf", 36'd0);

    // 6: reset during the fourth frame
    cono(36'o000064);
    for (int i = 0; i < 3; i++) feed(8'h85);
    tape_valid = 1; tape_frame = 8'h84; datai = 1;
    reset_n = 0;
    #1;
    check("t6_buf", iob_out, 36'd0);
    check("t6_pi", 36'(pi_req), 36'd0);
    check("t6_rdy", 36'(tape_ready), 36'd0);
    step();
    reset_n = 1; datai = 0;
    for (int i = 0; i < 20; i++) step();
    tape_valid = 0;

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      idle_inputs();
      ios          = ($urandom_range(0, 9) == 0) ? 7'($urandom) : DEV;
      cono_set     = ($urandom_range(0, 19) == 0);
      datai_done   = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0:       datai = 1;
        1:       status = 1;
        default: begin datai = 0; status = 0; end
      endcase
      iob_in       = {$urandom, $urandom};
      tape_valid   = $urandom_range(0, 1);
      tape_frame   = 8'($urandom);
      tape_present = $urandom_range(0, 1);
      reset_n      = ($urandom_range(0, 199) != 0);
      step();
    end
    idle_inputs();
    reset_n = 1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
